// File: rtl/disp_sched.sv
// Two-source display scheduler: round-robin accept, 14-cycle shift-and-add-3 BCD conversion, dwell hold.
// Optional macro DISP_BLANK_EN blanks leading zero digits (num4..num2) with 4'hF.
module disp_sched #(
  parameter int DWELL_CYCLES = 50000000,
  parameter int DWELL_W      = 26
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s0_valid,
  input  logic        s1_valid,
  input  logic [13:0] s0_data,
  input  logic [13:0] s1_data,
  output logic        s0_ready,
  output logic        s1_ready,
  output logic [3:0]  num1,
  output logic [3:0]  num2,
  output logic [3:0]  num3,
  output logic [3:0]  num4,
  output logic        src,
  output logic        busy
);

  // state | meaning
  // IDLE  | arbitrate between sources, display holds last result
  // CONV  | binary-to-BCD, one bit per cycle, 14 cycles
  // HOLD  | result shown for DWELL_CYCLES cycles before next accept
  typedef enum logic [1:0] {IDLE, CONV, HOLD} state_t;

  state_t             state;
  logic               prio;       // 1: source 1 wins the next tie
  logic               conv_src;
  logic [13:0]        bin_q;
  logic [15:0]        bcd_q;
  logic [3:0]         bit_cnt;
  logic [DWELL_W-1:0] dwell_cnt;

  logic        grant0, grant1;
  logic [13:0] sel_data, clamped;
  logic [15:0] bcd_adj, bcd_next, disp_next;

  // Readies are gated by rst so nothing is accepted while reset is held.
  assign grant0   = (state == IDLE) && !rst && s0_valid && (!s1_valid || !prio);
  assign grant1   = (state == IDLE) && !rst && s1_valid && !grant0;
  assign s0_ready = grant0;
  assign s1_ready = grant1;
  assign busy     = (state != IDLE);

  assign sel_data = grant1 ? s1_data : s0_data;
  assign clamped  = (sel_data > 14'd9999) ? 14'd9999 : sel_data;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < 4; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  assign bcd_next = 16'({bcd_adj, bin_q[13]});

  always_comb begin
    disp_next = bcd_next;
`ifdef DISP_BLANK_EN
    if (bcd_next[15:12] == 4'd0) begin
      disp_next[15:12] = 4'hF;
      if (bcd_next[11:8] == 4'd0) begin
        disp_next[11:8] = 4'hF;
        if (bcd_next[7:4] == 4'd0) disp_next[7:4] = 4'hF;
      end
    end
`else
    disp_next = bcd_next;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      prio      <= 1'b0;
      conv_src  <= 1'b0;
      bin_q     <= '0;
      bcd_q     <= '0;
      bit_cnt   <= '0;
      dwell_cnt <= '0;
      num1      <= 4'd0;
      num2      <= 4'd0;
      num3      <= 4'd0;
      num4      <= 4'd0;
      src       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant0 || grant1) begin
            bin_q    <= clamped;
            bcd_q    <= '0;
            bit_cnt  <= 4'd13;
            conv_src <= grant1;
            prio     <= grant0;
            state    <= CONV;
          end
        end
        CONV: begin
          bcd_q <= bcd_next;
          bin_q <= {bin_q[12:0], 1'b0};
          if (bit_cnt == 4'd0) begin
            num1      <= disp_next[3:0];
            num2      <= disp_next[7:4];
            num3      <= disp_next[11:8];
            num4      <= disp_next[15:12];
            src       <= conv_src;
            dwell_cnt <= DWELL_W'(DWELL_CYCLES - 1);
            state     <= HOLD;
          end else begin
            bit_cnt <= bit_cnt - 4'd1;
          end
        end
        HOLD: begin
          if (dwell_cnt == '0) state <= IDLE;
          else dwell_cnt <= dwell_cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_disp_sched.sv
// Self-checking bench for disp_sched with DWELL_CYCLES=4; reference model uses integer div/mod.
module tb_disp_sched;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s0_valid = 1'b0, s1_valid = 1'b0;
  logic [13:0] s0_data = '0, s1_data = '0;
  logic        s0_ready, s1_ready;
  logic [3:0]  num1, num2, num3, num4;
  logic        src, busy;

  int total = 0;
  int bad   = 0;
  int last_src = 1;
  logic [15:0] prev_disp = 16'h0000;
  logic        prev_src  = 1'b0;

  disp_sched #(.DWELL_CYCLES(4), .DWELL_W(3)) dut (
    .clk(clk), .rst(rst),
    .s0_valid(s0_valid), .s1_valid(s1_valid),
    .s0_data(s0_data), .s1_data(s1_data),
    .s0_ready(s0_ready), .s1_ready(s1_ready),
    .num1(num1), .num2(num2), .num3(num3), .num4(num4),
    .src(src), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] exp_disp(int v);
    int c;
    logic [3:0] d [4];
    c = (v > 9999) ? 9999 : v;
    d[0] = 4'(c % 10);
    d[1] = 4'((c / 10) % 10);
    d[2] = 4'((c / 100) % 10);
    d[3] = 4'(c / 1000);
`ifdef DISP_BLANK_EN
    if (c < 1000) d[3] = 4'hF;
    if (c < 100)  d[2] = 4'hF;
    if (c < 10)   d[1] = 4'hF;
`endif
    return {d[3], d[2], d[1], d[0]};
  endfunction

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (busy) begin
      total++; bad++;
      $display("FAIL wait_idle: busy still %b after %0d cycles, want 0", busy, n);
    end
  endtask

  // Drives one transaction and checks grant, display timing and dwell length.
  task automatic run_xact(input logic v0, input logic v1, input int d0, input int d1);
    int win;
    logic [15:0] want;
    wait_idle();
    @(posedge clk); #1;
    s0_valid = v0; s1_valid = v1;
    s0_data = 14'(d0); s1_data = 14'(d1);
    if (v0 && v1) win = (last_src == 0) ? 1 : 0;
    else win = v0 ? 0 : 1;
    @(negedge clk);
    total++;
    if ({s1_ready, s0_ready} !== ((win == 1) ? 2'b10 : 2'b01)) begin
      bad++;
      $display("FAIL grant: ready{s1,s0}=%b want winner s%0d", {s1_ready, s0_ready}, win);
    end
    @(posedge clk); #1;
    s0_valid = 1'b0; s1_valid = 1'b0;
    last_src = win;
    want = exp_disp((win == 1) ? d1 : d0);
    repeat (13) @(posedge clk);
    @(negedge clk);
    total++;
    if ({num4, num3, num2, num1} !== prev_disp || src !== prev_src) begin
      bad++;
      $display("FAIL early_update: disp=%h src=%b at T+14 want %h src=%b", {num4, num3, num2, num1}, src, prev_disp, prev_src);
    end
    @(posedge clk); @(negedge clk);
    total++;
    if ({num4, num3, num2, num1} !== want || src !== 1'(win)) begin
      bad++;
      $display("FAIL result: disp=%h src=%b want %h src=%0d", {num4, num3, num2, num1}, src, want, win);
    end
    prev_disp = want; prev_src = 1'(win);
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL dwell_busy: busy=%b at T+18 want 1", busy);
    end
    @(posedge clk); @(negedge clk);
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL dwell_end: busy=%b at T+19 want 0", busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({num4, num3, num2, num1} !== 16'h0000 || src !== 1'b0 || busy !== 1'b0 || s0_ready !== 1'b0 || s1_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: disp=%h src=%b busy=%b rdy=%b%b want 0000 0 0 00", {num4, num3, num2, num1}, src, busy, s1_ready, s0_ready);
    end
    rst = 1'b0;
    last_src = 1; prev_disp = 16'h0000; prev_src = 1'b0;
  endtask

  task automatic test_basic();
    run_xact(1'b1, 1'b0, 1234, 0);
    run_xact(1'b1, 1'b0, 7, 0);
  endtask

  task automatic test_boundaries();
    run_xact(1'b0, 1'b1, 0, 16383);
    run_xact(1'b0, 1'b1, 0, 0);
    run_xact(1'b1, 1'b0, 9999, 0);
    run_xact(1'b1, 1'b0, 10000, 0);
  endtask

  task automatic test_round_robin();
    run_xact(1'b1, 1'b1, 111, 222);
    run_xact(1'b1, 1'b1, 333, 444);
    run_xact(1'b1, 1'b1, 555, 666);
  endtask

  task automatic test_idle_hold();
    wait_idle();
    repeat (10) @(negedge clk);
    total++;
    if ({num4, num3, num2, num1} !== prev_disp || busy !== 1'b0) begin
      bad++;
      $display("FAIL idle_hold: disp=%h busy=%b want %h 0", {num4, num3, num2, num1}, busy, prev_disp);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      int pat;
      pat = int'($urandom_range(1, 3));
      run_xact(pat[0], pat[1], int'($urandom_range(0, 16383)), int'($urandom_range(0, 16383)));
    end
  endtask

  task automatic test_reset_mid();
    wait_idle();
    @(posedge clk); #1;
    s0_valid = 1'b1; s0_data = 14'd5678;
    @(posedge clk); #1;
    s0_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    s0_valid = 1'b1; s1_valid = 1'b1; s0_data = 14'd42; s1_data = 14'd300;
    #1;
    total++;
    if ({num4, num3, num2, num1} !== 16'h0000 || busy !== 1'b0 || src !== 1'b0 || s0_ready !== 1'b0 || s1_ready !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: disp=%h busy=%b src=%b rdy=%b%b want 0000 0 0 00", {num4, num3, num2, num1}, busy, src, s1_ready, s0_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    last_src = 1; prev_disp = 16'h0000; prev_src = 1'b0;
    @(negedge clk);
    total++;
    if ({s1_ready, s0_ready} !== 2'b01) begin
      bad++;
      $display("FAIL post_reset_tie: ready{s1,s0}=%b want 01", {s1_ready, s0_ready});
    end
    @(posedge clk); #1;
    s0_valid = 1'b0; s1_valid = 1'b0;
    last_src = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      total++;
      if ({num4, num3, num2, num1} !== 16'h0000) begin
        bad++;
        $display("FAIL stale_value: disp=%h in conversion cycle %0d want 0000", {num4, num3, num2, num1}, k + 1);
      end
      @(posedge clk);
    end
    @(negedge clk);
    total++;
    if ({num4, num3, num2, num1} !== exp_disp(42) || src !== 1'b0) begin
      bad++;
      $display("FAIL post_reset_result: disp=%h src=%b want %h 0", {num4, num3, num2, num1}, src, exp_disp(42));
    end
    prev_disp = exp_disp(42); prev_src = 1'b0;
    run_xact(1'b1, 1'b1, 1000, 2000);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_round_robin();
    test_idle_hold();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, want completion");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/disp_sched.md
DISP_SCHED -- requirements
Module: disp_sched

Interface
REQ-001 SHALL have parameter DWELL_CYCLES, default 50000000, minimum number of clk cycles a result is held on the display before the next source is accepted (must be >= 1).
REQ-002 SHALL have parameter DWELL_W, default 26, width of the dwell counter (2^DWELL_W > DWELL_CYCLES).
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have ports s0_valid / s1_valid  input  1 each  source 0/1 presents a value.
REQ-006 SHALL have ports s0_data / s1_data  input  14 each  unsigned binary value from source 0/1.
REQ-007 SHALL have ports s0_ready / s1_ready  output  1 each  value accepted this cycle when valid && ready.
REQ-008 SHALL have ports num1..num4  output  4 each  digits for the 4-digit display driver: num1 ones (rightmost) to num4 thousands; 4'hF means blank.
REQ-009 SHALL have port src  output  1  source of the value currently displayed.
REQ-010 SHALL have port busy  output  1  high in CONV and HOLD.

Function
REQ-011 SHALL implement FSM states IDLE, CONV, HOLD; reset state IDLE.
REQ-012 In IDLE, SHALL grant one source with valid high, driving its ready high combinationally from registered state and the valids; the other ready SHALL be low.
REQ-013 With both valids high in IDLE, SHALL grant the source not served last (round-robin); after reset, source 0 wins the first tie.
REQ-014 Ready SHALL be low in CONV and HOLD; at most one ready high per cycle; never high for a source whose valid is low.
REQ-015 On acceptance (cycle T), SHALL latch the data, clamping values > 9999 to 9999, record the source, and enter CONV at T+1.
REQ-016 CONV SHALL perform binary-to-BCD by shift-and-add-3, one bit per cycle, exactly 14 cycles.
REQ-017 num1..num4 and src SHALL update together on one edge at the end of CONV (visible from T+15) and otherwise hold; no intermediate BCD values appear on num1..num4.
REQ-018 HOLD SHALL last exactly DWELL_CYCLES cycles starting at T+15, then return to IDLE; a new acceptance is possible no earlier than T+15+DWELL_CYCLES.
REQ-019 Valid changes during CONV/HOLD SHALL be ignored; a source must keep valid high until it sees ready.
REQ-020 With no valid in IDLE, SHALL stay in IDLE and keep displaying the last result.

Reset
REQ-021 Asserting rst at any time, including mid-CONV or mid-HOLD, SHALL immediately force IDLE, num1..num4 = 0, src = 0, busy = 0, both readys = 0, dwell counter and shift registers cleared, round-robin pointer favouring source 0.
REQ-022 On rst deassertion, the first clk edge SHALL evaluate IDLE arbitration normally.

Configuration
REQ-023 Macro DISP_BLANK_EN defined: at result load, leading zero digits in num4..num2 SHALL be set to 4'hF; num1 is never blanked (value 0 shows one '0').
REQ-024 Macro DISP_BLANK_EN undefined: all four digits SHALL show 0-9 including leading zeros; 4'hF never output.
REQ-025 The reset value of num1..num4 SHALL be 0 in both configurations.

Verification (DWELL_CYCLES = 4)
REQ-026 s0_valid=1, s0_data=1234 at T -> s0_ready=1 at T; num4..num1 = 1,2,3,4, src=0 at T+15; busy low and ready possible again at T+19.
REQ-027 s0 and s1 both valid continuously from reset -> grants alternate s0, s1, s0; src alternates 0,1,0; never two readys in one cycle.
REQ-028 s1_data=16383 -> displayed 9,9,9,9; s1_data=0 -> 0,0,0,0 (undefined) / F,F,F,0 (DISP_BLANK_EN).
REQ-029 s0_data=7 with DISP_BLANK_EN -> num4..num1 = F,F,F,7; without -> 0,0,0,7.
REQ-030 rst pulsed at T+8 of a conversion of 5678 -> num1..num4 = 0, busy=0 immediately; previous value never appears; next tie after reset granted to s0.
